// File: rtl/mips_pkg.sv
// Shared MIPS definitions: branch-type encodings and BHT counter constants.
// Used by branch_resolve_unit and its optional branch_bht (BRANCH_PREDICT_EN).
package mips_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BLEZ = 3'd3,
      BR_BGTZ = 3'd4,
      BR_BLTZ = 3'd5,
      BR_BGEZ = 3'd6,
      BR_JUMP = 3'd7
   } br_type_e;

   localparam logic [1:0] BHT_CNT_RESET = 2'b01;
   localparam logic [1:0] BHT_CNT_MAX   = 2'b11;
   localparam logic [1:0] BHT_CNT_MIN   = 2'b00;

   // Only conditional branches train the history table; JUMP and NONE never do.
   function automatic logic is_cond_branch(input br_type_e t);
      is_cond_branch = (t != BR_NONE) && (t != BR_JUMP);
   endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle of resolve-side inputs, fetch-side lookup and registered results
// of branch_resolve_unit.
interface branch_resolve_unit_if
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             valid_in;
   br_type_e         br_type;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic [WIDTH-1:0] pc;
   logic [15:0]      imm;
   logic             pred_in;
   logic [WIDTH-1:0] lookup_pc;
   logic             pred_taken;
   logic             valid_out;
   logic             taken_out;
   logic [WIDTH-1:0] target_out;
   logic             mispredict_out;

   modport master (
      output valid_in, br_type, rs_val, rt_val, pc, imm, pred_in, lookup_pc,
      input  pred_taken, valid_out, taken_out, target_out, mispredict_out
   );

   modport slave (
      input  valid_in, br_type, rs_val, rt_val, pc, imm, pred_in, lookup_pc,
      output pred_taken, valid_out, taken_out, target_out, mispredict_out
   );
endinterface

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters; the read is combinational
// from stored state, so a same-cycle lookup sees the pre-update value.
module branch_bht
   import mips_pkg::*;
#(
   parameter int BHT_DEPTH = 16,
   localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] lookup_idx,
   output logic             pred_taken,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   logic [1:0] cnt_r [BHT_DEPTH];

   // Counter storage: reset to weakly-not-taken, then saturating train.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            cnt_r[i] <= BHT_CNT_RESET;
         end
      end else if (upd_en) begin
         if (upd_taken) begin
            if (cnt_r[upd_idx] != BHT_CNT_MAX) begin
               cnt_r[upd_idx] <= cnt_r[upd_idx] + 2'd1;
            end
         end else if (cnt_r[upd_idx] != BHT_CNT_MIN) begin
            cnt_r[upd_idx] <= cnt_r[upd_idx] - 2'd1;
         end
      end
   end

   assign pred_taken = cnt_r[lookup_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branch outcome/target with one-cycle registered results.
// Define BRANCH_PREDICT_EN to build the branch_bht predictor; otherwise pred_taken is 0.
module branch_resolve_unit
   import mips_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int BHT_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   branch_resolve_unit_if.slave bus
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic             taken_s;
   logic             rs_neg_s;
   logic             rs_zero_s;
   logic [WIDTH-1:0] imm_ext_s;
   logic [WIDTH-1:0] target_s;
   logic             pred_s;
   logic             unused_s;

   logic             valid_r;
   logic             taken_r;
   logic             mispredict_r;
   logic [WIDTH-1:0] target_r;

   assign rs_neg_s  = bus.rs_val[WIDTH-1];
   assign rs_zero_s = (bus.rs_val == {WIDTH{1'b0}});
   assign imm_ext_s = WIDTH'($signed(bus.imm));
   // Word offset -> byte offset; the sum wraps modulo 2^WIDTH by design.
   assign target_s  = bus.pc + WIDTH'(32'd4) + {imm_ext_s[WIDTH-3:0], 2'b00};

   // Branch condition evaluation, signed on rs.
   always_comb begin
      taken_s = 1'b0;
      case (bus.br_type)
         BR_BEQ:  taken_s = (bus.rs_val == bus.rt_val);
         BR_BNE:  taken_s = (bus.rs_val != bus.rt_val);
         BR_BLEZ: taken_s = rs_neg_s | rs_zero_s;
         BR_BGTZ: taken_s = ~rs_neg_s & ~rs_zero_s;
         BR_BLTZ: taken_s = rs_neg_s;
         BR_BGEZ: taken_s = ~rs_neg_s;
         BR_JUMP: taken_s = 1'b1;
         default: taken_s = 1'b0;
      endcase
   end

   // Result registers; target holds across idle cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r      <= 1'b0;
         taken_r      <= 1'b0;
         mispredict_r <= 1'b0;
         target_r     <= {WIDTH{1'b0}};
      end else begin
         valid_r      <= bus.valid_in;
         taken_r      <= bus.valid_in & taken_s;
         mispredict_r <= bus.valid_in & (taken_s ^ bus.pred_in);
         if (bus.valid_in) begin
            target_r <= target_s;
         end
      end
   end

   assign bus.valid_out      = valid_r;
   assign bus.taken_out      = taken_r;
   assign bus.mispredict_out = mispredict_r;
   assign bus.target_out     = target_r;

`ifdef BRANCH_PREDICT_EN
   logic upd_en_s;
   assign upd_en_s = bus.valid_in & is_cond_branch(bus.br_type);

   branch_bht #(
      .BHT_DEPTH (BHT_DEPTH)
   ) u_bht (
      .clk        (clk),
      .reset      (reset),
      .lookup_idx (bus.lookup_pc[IDX_W+1:2]),
      .pred_taken (pred_s),
      .upd_en     (upd_en_s),
      .upd_idx    (bus.pc[IDX_W+1:2]),
      .upd_taken  (taken_s)
   );

   assign unused_s = ^{bus.lookup_pc[WIDTH-1:IDX_W+2], bus.lookup_pc[1:0]};
`else
   assign pred_s   = 1'b0;
   assign unused_s = ^bus.lookup_pc;
`endif

   assign bus.pred_taken = pred_s;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit; follows BRANCH_PREDICT_EN if defined.
module tb_branch_resolve_unit;
   import mips_pkg::*;

   localparam int WIDTH = 32;

   typedef struct packed {
      logic        valid;
      logic        taken;
      logic        mispredict;
      logic [31:0] target;
   } result_t;

   logic        clk = 1'b0;
   logic        reset;
   result_t     sb_q[$];
   result_t     got;
   result_t     exp_r;
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] last_target;
   logic [1:0]  bht_m [16];
   logic        pred_seen;
   logic        pred_exp;

   always #5 clk = ~clk;

   branch_resolve_unit_if #(.WIDTH(WIDTH)) bus ();

   branch_resolve_unit #(.WIDTH(WIDTH), .BHT_DEPTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic model_taken(input br_type_e t, input logic [31:0] rs, input logic [31:0] rt);
      case (t)
         BR_BEQ:  return rs == rt;
         BR_BNE:  return rs != rt;
         BR_BLEZ: return $signed(rs) <= 32'sd0;
         BR_BGTZ: return $signed(rs) > 32'sd0;
         BR_BLTZ: return $signed(rs) < 32'sd0;
         BR_BGEZ: return $signed(rs) >= 32'sd0;
         BR_JUMP: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // One cycle: drive at negedge, sample pred_taken, push expected, clock, update model.
   task automatic drive(input logic rst, input logic v, input br_type_e t,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] p,
                        input logic [15:0] imm, input logic pr, input logic [31:0] lpc);
      result_t e;
      logic    tk;
      logic [3:0] ui;
      @(negedge clk);
      reset = rst;
      bus.valid_in = v; bus.br_type = t; bus.rs_val = rs; bus.rt_val = rt;
      bus.pc = p; bus.imm = imm; bus.pred_in = pr; bus.lookup_pc = lpc;
      tk = model_taken(t, rs, rt);
`ifdef BRANCH_PREDICT_EN
      pred_exp = bht_m[lpc[5:2]][1];
`else
      pred_exp = 1'b0;
`endif
      #1 pred_seen = bus.pred_taken;
      e = result_t'(35'd0);
      if (rst) begin
         last_target = 32'd0;
      end else if (v) begin
         e.valid = 1'b1;
         e.taken = tk;
         e.mispredict = tk ^ pr;
         e.target = p + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
         last_target = e.target;
      end else begin
         e.target = last_target;
      end
      sb_q.push_back(e);
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
      end else if (v && t != BR_NONE && t != BR_JUMP) begin
         ui = p[5:2];
         if (tk && bht_m[ui] != 2'b11) bht_m[ui] = bht_m[ui] + 2'd1;
         else if (!tk && bht_m[ui] != 2'b00) bht_m[ui] = bht_m[ui] - 2'd1;
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, BR_NONE, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 32'd0);
      got = {bus.valid_out, bus.taken_out, bus.mispredict_out, bus.target_out};
      exp_r = sb_q.pop_front();
      n_cmp++;
      if (got !== exp_r) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", got, exp_r); end
      n_cmp++;
      if (pred_seen !== pred_exp) begin n_fail++; $display("FAIL reset_pred: got %b expected %b", pred_seen, pred_exp); end
   endtask

   task automatic test_beq();
      drive(1'b0, 1'b1, BR_BEQ, 32'd5, 32'd5, 32'h100, 16'h0004, 1'b0, 32'h100);
      got = {bus.valid_out, bus.taken_out, bus.mispredict_out, bus.target_out};
      exp_r = sb_q.pop_front();
      n_cmp++;
      if (got !== exp_r) begin n_fail++; $display("FAIL beq_sb: got %h expected %h", got, exp_r); end
      n_cmp++;
      if ({bus.valid_out, bus.taken_out, bus.mispredict_out} !== 3'b111 || bus.target_out !== 32'h114) begin
         n_fail++;
         $display("FAIL beq_const: got v%b t%b m%b tgt %h expected v1 t1 m1 tgt 00000114",
                  bus.valid_out, bus.taken_out, bus.mispredict_out, bus.target_out);
      end
   endtask

   task automatic test_cond_types();
      br_type_e    tt[12] = '{BR_BNE, BR_BNE, BR_BLEZ, BR_BLEZ, BR_BLEZ, BR_BGTZ,
                              BR_BGTZ, BR_BGTZ, BR_BLTZ, BR_BGEZ, BR_NONE, BR_JUMP};
      logic [31:0] rs[12] = '{32'd1, 32'd7, 32'd0, 32'd1, 32'h80000000, 32'd1,
                              32'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd9, 32'd0};
      logic [31:0] rt[12] = '{32'd2, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0,
                              32'd0, 32'd0, 32'd0, 32'd0, 32'd9, 32'd0};
      logic        pr[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1'b1, tt[i], rs[i], rt[i], 32'h1000 + 32'(i) * 32'd4,
               (i % 2 == 0) ? 16'hFFFE : 16'h0123, pr[i], 32'h1000 + 32'(i) * 32'd4);
         got = {bus.valid_out, bus.taken_out, bus.mispredict_out, bus.target_out};
         exp_r = sb_q.pop_front();
         n_cmp++;
         if (got !== exp_r) begin n_fail++; $display("FAIL cond_%0d: got %h expected %h", i, got, exp_r); end
         n_cmp++;
         if (pred_seen !== pred_exp) begin n_fail++; $display("FAIL cond_pred_%0d: got %b expected %b", i, pred_seen, pred_exp); end
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b0, 1'b1, BR_BLTZ, 32'hFFFFFFFF, 32'd0, 32'h200, 16'h0010, 1'b0, 32'h200);
      got = {bus.valid_out, bus.taken_out, bus.mispredict_out, bus.target_out};
      exp_r = sb_q.pop_front();
      n_cmp++;
      if (got !== exp_r || bus.taken_out !== 1'b1) begin n_fail++; $display("FAIL b2b_bltz: got %h expected %h", got, exp_r); end
      drive(1'b0, 1'b1, BR_BGEZ, 32'h80000000, 32'd0, 32'h204, 16'h0020, 1'b1, 32'h204);
      got = {bus.valid_out, bus.taken_out, bus.mispredict_out, bus.target_out};
      exp_r = sb_q.pop_front();
      n_cmp++;
      if (got !== exp_r || bus.taken_out !== 1'b0) begin n_fail++; $display("FAIL b2b_bgez: got %h expected %h", got, exp_r); end
      drive(1'b0, 1'b0, BR_BEQ, 32'd3, 32'd3, 32'h300, 16'h0040, 1'b1, 32'h300);
      got = {bus.valid_out, bus.taken_out, bus.mispredict_out, bus.target_out};
      exp_r = sb_q.pop_front();
      n_cmp++;
      if (got !== exp_r) begin n_fail++; $display("FAIL idle_hold: got %h expected %h", got, exp_r); end
   endtask

   task automatic test_wrap();
      drive(1'b0, 1'b1, BR_JUMP, 32'd0, 32'd0, 32'hFFFFFFF8, 16'h0001, 1'b1, 32'd0);
      got = {bus.valid_out, bus.taken_out, bus.mispredict_out, bus.target_out};
      exp_r = sb_q.pop_front();
      n_cmp++;
      if (got !== exp_r) begin n_fail++; $display("FAIL wrap_sb: got %h expected %h", got, exp_r); end
      n_cmp++;
      if (bus.target_out !== 32'h0 || bus.taken_out !== 1'b1) begin
         n_fail++; $display("FAIL wrap_const: got tgt %h t%b expected tgt 00000000 t1", bus.target_out, bus.taken_out);
      end
   endtask

   task automatic test_bht();
`ifdef BRANCH_PREDICT_EN
      logic pc_exp[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
      logic pc_exp[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
      drive(1'b1, 1'b0, BR_NONE, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 32'h40);
      exp_r = sb_q.pop_front();
      for (int i = 0; i < 8; i++) begin
         if (i < 3) drive(1'b0, 1'b1, BR_BNE, 32'd1, 32'd2, 32'h40, 16'h0002, 1'b0, 32'h40);
         else if (i < 7) drive(1'b0, 1'b1, BR_BNE, 32'd3, 32'd3, 32'h40, 16'h0002, 1'b1, 32'h40);
         else drive(1'b0, 1'b0, BR_NONE, 32'd0, 32'd0, 32'h40, 16'd0, 1'b0, 32'h40);
         got = {bus.valid_out, bus.taken_out, bus.mispredict_out, bus.target_out};
         exp_r = sb_q.pop_front();
         n_cmp++;
         if (got !== exp_r) begin n_fail++; $display("FAIL bht_out_%0d: got %h expected %h", i, got, exp_r); end
         n_cmp++;
         if (pred_seen !== pc_exp[i] || pred_seen !== pred_exp) begin
            n_fail++; $display("FAIL bht_pred_%0d: got %b expected %b", i, pred_seen, pc_exp[i]);
         end
      end
   endtask

   task automatic test_reset_with_valid();
      drive(1'b0, 1'b1, BR_BNE, 32'd1, 32'd2, 32'h40, 16'h0100, 1'b0, 32'h40);
      exp_r = sb_q.pop_front();
      drive(1'b1, 1'b1, BR_BEQ, 32'd5, 32'd5, 32'h40, 16'h0004, 1'b0, 32'h40);
      got = {bus.valid_out, bus.taken_out, bus.mispredict_out, bus.target_out};
      exp_r = sb_q.pop_front();
      n_cmp++;
      if (got !== exp_r || bus.valid_out !== 1'b0 || bus.target_out !== 32'h0) begin
         n_fail++; $display("FAIL rst_win: got %h expected %h", got, exp_r);
      end
      drive(1'b0, 1'b0, BR_NONE, 32'd0, 32'd0, 32'h40, 16'd0, 1'b0, 32'h40);
      exp_r = sb_q.pop_front();
      n_cmp++;
      if (pred_seen !== 1'b0) begin n_fail++; $display("FAIL rst_bht_pred: got %b expected 0", pred_seen); end
      drive(1'b0, 1'b1, BR_BNE, 32'd1, 32'd2, 32'h40, 16'd0, 1'b0, 32'h40);
      exp_r = sb_q.pop_front();
      drive(1'b0, 1'b0, BR_NONE, 32'd0, 32'd0, 32'h40, 16'd0, 1'b0, 32'h40);
      got = {bus.valid_out, bus.taken_out, bus.mispredict_out, bus.target_out};
      exp_r = sb_q.pop_front();
      n_cmp++;
      if (got !== exp_r) begin n_fail++; $display("FAIL rst_after_idle: got %h expected %h", got, exp_r); end
      n_cmp++;
      if (pred_seen !== pred_exp) begin n_fail++; $display("FAIL rst_bht_01: got %b expected %b", pred_seen, pred_exp); end
   endtask

   initial begin
      reset = 1'b1;
      bus.valid_in = 1'b0; bus.br_type = BR_NONE; bus.rs_val = 32'd0; bus.rt_val = 32'd0;
      bus.pc = 32'd0; bus.imm = 16'd0; bus.pred_in = 1'b0; bus.lookup_pc = 32'd0;
      last_target = 32'd0;
      for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
      repeat (2) @(posedge clk);
      test_reset();
      test_beq();
      test_cond_types();
      test_back_to_back();
      test_wrap();
      test_bht();
      test_reset_with_valid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
